// File: rtl/uart_rx_ctrl_pkg.sv
// Shared types and constants for the oversampling UART receiver.
package uart_rx_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } rx_state_e;

  localparam int unsigned PRESC_8  = 8;
  localparam int unsigned PRESC_16 = 16;
  localparam int unsigned PRESC_32 = 32;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit oversampling counter, 3-sample majority vote and bit-boundary strobe.
module uart_rx_sampler
  import uart_rx_ctrl_pkg::*;
#(
  parameter int unsigned PRESC_W = 6
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               run_i,
  input  logic               clr_i,
  input  logic               rx_i,
  input  logic [PRESC_W-1:0] prescale_i,
  output logic               bit_o,
  output logic               bit_bnd_c_o
);

  logic [PRESC_W-1:0] edge_cnt_q, edge_cnt_d;
  logic [PRESC_W-1:0] half;
  logic               smp0_q, smp0_d;
  logic               smp1_q, smp1_d;
  logic               bit_q, bit_d;
  logic               smp_rdy_c;

  // Vote uses the two earlier samples plus the live line at the third point.
  always_comb begin
    half        = prescale_i >> 1;
    smp_rdy_c   = (edge_cnt_q == half + PRESC_W'(1));
    bit_bnd_c_o = (edge_cnt_q == prescale_i - PRESC_W'(1));
    edge_cnt_d  = edge_cnt_q + PRESC_W'(1);
    if (!run_i || clr_i || bit_bnd_c_o) begin
      edge_cnt_d = '0;
    end
    smp0_d = (edge_cnt_q == half - PRESC_W'(1)) ? rx_i : smp0_q;
    smp1_d = (edge_cnt_q == half) ? rx_i : smp1_q;
    bit_d  = smp_rdy_c ? maj3(smp0_q, smp1_q, rx_i) : bit_q;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      edge_cnt_q <= '0;
      smp0_q     <= 1'b0;
      smp1_q     <= 1'b0;
      bit_q      <= 1'b0;
    end else begin
      edge_cnt_q <= edge_cnt_d;
      smp0_q     <= smp0_d;
      smp1_q     <= smp1_d;
      bit_q      <= bit_d;
    end
  end

  assign bit_o = bit_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receiver: frame FSM, bit counter, shift/parity datapath and status pulses.
module uart_rx_ctrl
  import uart_rx_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PRESC_W    = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [PRESC_W-1:0]    Prescale,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  STOP2,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err,
  output logic                  brk_det,
  output logic                  busy
);

  localparam int unsigned          BIT_CNT_W = 4;
  localparam logic [BIT_CNT_W-1:0] LAST_DATA = BIT_CNT_W'(DATA_WIDTH - 1);

  rx_state_e             state_q, state_d;
  logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
  logic                  par_acc_q, par_acc_d;
  logic                  par_bad_q, par_bad_d;
  logic                  stp_bad_q, stp_bad_d;
  logic                  zero_q, zero_d;
  logic [PRESC_W-1:0]    presc_q, presc_d;
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic                  stop2_q, stop2_d;
  logic                  valid_q, valid_d;
  logic                  perr_q, perr_d;
  logic                  serr_q, serr_d;
  logic                  brk_q, brk_d;
  logic                  busy_q;
  logic                  smp_bit;
  logic                  bit_bnd_c;
  logic                  run_c, clr_c;
  logic                  last_stop_c, zero_now_c, stp_fault_c;

  // In BREAK the edge counter doubles as the count of consecutive high cycles.
  assign run_c = (state_q != ST_IDLE);
  assign clr_c = (state_q == ST_BREAK) && !RX_IN;

  uart_rx_sampler #(
    .PRESC_W (PRESC_W)
  ) u_sampler (
    .clk_i       (CLK),
    .rst_ni      (RST),
    .run_i       (run_c),
    .clr_i       (clr_c),
    .rx_i        (RX_IN),
    .prescale_i  (presc_q),
    .bit_o       (smp_bit),
    .bit_bnd_c_o (bit_bnd_c)
  );

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    p_data_d    = p_data_q;
    par_acc_d   = par_acc_q;
    par_bad_d   = par_bad_q;
    stp_bad_d   = stp_bad_q;
    zero_d      = zero_q;
    presc_d     = presc_q;
    par_en_d    = par_en_q;
    par_typ_d   = par_typ_q;
    stop2_d     = stop2_q;
    valid_d     = 1'b0;
    perr_d      = 1'b0;
    serr_d      = 1'b0;
    brk_d       = 1'b0;
    last_stop_c = stop2_q ? (bit_cnt_q == BIT_CNT_W'(1)) : 1'b1;
    zero_now_c  = zero_q & ((bit_cnt_q != '0) | ~smp_bit);
    stp_fault_c = stp_bad_q | ~smp_bit;

    unique case (state_q)
      ST_IDLE: begin
        if (!RX_IN) begin
          state_d   = ST_START;
          bit_cnt_d = '0;
          par_acc_d = 1'b0;
          par_bad_d = 1'b0;
          stp_bad_d = 1'b0;
          zero_d    = 1'b1;
          presc_d   = Prescale;
          par_en_d  = PAR_EN;
          par_typ_d = PAR_TYP;
          stop2_d   = STOP2;
        end
      end
      ST_START: begin
        if (bit_bnd_c) begin
          state_d   = smp_bit ? ST_IDLE : ST_DATA;
          bit_cnt_d = '0;
        end
      end
      ST_DATA: begin
        if (bit_bnd_c) begin
          shift_d   = {smp_bit, shift_q[DATA_WIDTH-1:1]};
          par_acc_d = par_acc_q ^ smp_bit;
          zero_d    = zero_q & ~smp_bit;
          bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
          if (bit_cnt_q == LAST_DATA) begin
            bit_cnt_d = '0;
            state_d   = par_en_q ? ST_PARITY : ST_STOP;
          end
        end
      end
      ST_PARITY: begin
        if (bit_bnd_c) begin
          par_bad_d = (par_acc_q ^ (par_typ_q == PAR_ODD)) ^ smp_bit;
          zero_d    = zero_q & ~smp_bit;
          state_d   = ST_STOP;
        end
      end
      ST_STOP: begin
        if (bit_bnd_c) begin
          zero_d    = zero_now_c;
          stp_bad_d = stp_fault_c;
          bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
          if (last_stop_c) begin
            bit_cnt_d = '0;
            if (zero_now_c) begin
              brk_d   = 1'b1;
              state_d = ST_BREAK;
            end else begin
              perr_d  = par_bad_q;
              serr_d  = stp_fault_c;
              state_d = ST_IDLE;
              if (!par_bad_q && !stp_fault_c) begin
                valid_d  = 1'b1;
                p_data_d = shift_q;
              end
            end
          end
        end
      end
      ST_BREAK: begin
        if (bit_bnd_c && RX_IN) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      p_data_q  <= '0;
      par_acc_q <= 1'b0;
      par_bad_q <= 1'b0;
      stp_bad_q <= 1'b0;
      zero_q    <= 1'b0;
      presc_q   <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      stop2_q   <= 1'b0;
      valid_q   <= 1'b0;
      perr_q    <= 1'b0;
      serr_q    <= 1'b0;
      brk_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      p_data_q  <= p_data_d;
      par_acc_q <= par_acc_d;
      par_bad_q <= par_bad_d;
      stp_bad_q <= stp_bad_d;
      zero_q    <= zero_d;
      presc_q   <= presc_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
      stop2_q   <= stop2_d;
      valid_q   <= valid_d;
      perr_q    <= perr_d;
      serr_q    <= serr_d;
      brk_q     <= brk_d;
      busy_q    <= (state_d != ST_IDLE);
    end
  end

  assign P_DATA     = p_data_q;
  assign data_valid = valid_q;
  assign par_err    = perr_q;
  assign stp_err    = serr_q;
  assign brk_det    = brk_q;
  assign busy       = busy_q;

endmodule
